// File: rtl/kv_vector_streamer_pkg.sv
// kv_vector_streamer_pkg: shared widths, vector typedefs and the FIFO entry struct for the K/V streamers
package kv_vector_streamer_pkg;
  localparam int BLOCK_W = 64;
  localparam int ELEM_W = 8;
  localparam int DIM = 64;
  localparam int VEC_W = DIM * ELEM_W;
  localparam int BEATS = VEC_W / BLOCK_W;
  localparam int DEPTH = 2;
  localparam int NUM_PES = 4;
  localparam int SEQ_LEN = 128;
  localparam int PTR_W = $clog2(DEPTH) + 1;
  typedef logic [BLOCK_W-1:0] mem_block_t;
  typedef logic [VEC_W-1:0] k_vector_t;
  typedef logic [VEC_W-1:0] v_vector_t;
  typedef struct packed {
    k_vector_t vector;
    logic last;
  } kv_entry_t;
endpackage

// File: rtl/kv_vector_streamer_vec_fifo.sv
// kv_vector_streamer_vec_fifo: DEPTH-entry vector FIFO with register-driven head, extra-MSB pointers, clear flush
module kv_vector_streamer_vec_fifo
  import kv_vector_streamer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  kv_entry_t        din,
  output kv_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [PTR_W-1:0] count
);
  localparam int AW = PTR_W - 1;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  kv_entry_t mem [DEPTH];
  assign count = wr_ptr - rd_ptr;
  assign empty = count == '0;
  assign full = count == PTR_W'(DEPTH);
  assign head = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/kv_vector_streamer.sv
// kv_vector_streamer: packs memory beats into K/V vectors, queues them, broadcasts to all PEs, tags sequence end
module kv_vector_streamer
  import kv_vector_streamer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               out_valid,
  output logic [VEC_W-1:0]   out_vector,
  output logic               out_last,
  input  logic [NUM_PES-1:0] pe_rdy,
  output logic [PTR_W-1:0]   occupancy
);
  localparam int BW = $clog2(BEATS);
  localparam int SW = $clog2(SEQ_LEN);
  logic [BW-1:0] beat_cnt;
  logic [SW-1:0] vec_cnt;
  mem_block_t beats_q [BEATS-1];
  logic last_beat, accept, push, pop, full, empty;
  kv_entry_t din, head;
  assign last_beat = beat_cnt == BW'(BEATS - 1);
  assign pop = out_valid & (&pe_rdy);
  assign in_ready = clear | ~last_beat | ~full | pop;
  assign accept = in_valid & in_ready & ~clear;
  assign push = accept & last_beat;
  always_comb begin
    din.vector = '0;
    for (int i = 0; i < BEATS - 1; i++) din.vector[i*BLOCK_W +: BLOCK_W] = beats_q[i];
    din.vector[(BEATS-1)*BLOCK_W +: BLOCK_W] = in_data;
    din.last = vec_cnt == SW'(SEQ_LEN - 1);
  end
  always_ff @(posedge clk) begin
    if (accept && !last_beat) beats_q[beat_cnt] <= in_data;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
      vec_cnt <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
      vec_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      vec_cnt <= !last_beat ? vec_cnt : din.last ? '0 : vec_cnt + 1'b1;
    end
  end
  kv_vector_streamer_vec_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );
  assign out_valid = ~empty;
  assign out_vector = head.vector;
  assign out_last = head.last;
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) (full & push) |-> pop);
  a_head_stable: assert property (@(posedge clk) disable iff (!rst) (out_valid & ~pop & ~clear) |=> $stable(out_vector));
  a_occ_bound: assert property (@(posedge clk) disable iff (!rst) occupancy <= PTR_W'(DEPTH));
endmodule
